echo_indication_output: RTL and testbench

Transmit-side serializer for the Echo indication interface. Accepts `heard` and `heard2` indication method calls from the echo core, packs each into a 96-bit pipe word laid out as {field2[95:64], field1[63:32], tag[31:0]}, buffers the words in a small FIFO and drains them onto the outbound `pipe$enq` method toward the host transport. It is the counterpart of the request-side input decoder: every word it emits must decode there by the same tag and field positions.

---
 rtl/echo_indication_output.sv | 93 +++++++++
 tb/tb_echo_indication_output.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_output.sv
// echo_indication_output
//
// Transmit-side serializer for the Echo indication interface. Each heard
// or heard2 call becomes one 96-bit pipe word laid out as
// {field2[95:64], field1[63:32], tag[31:0]}. Words are queued in a small
// FIFO and drained onto pipe_enq toward the host transport. The request-side
// input decoder uses the same tag values and field positions to decode them.
//
// Handshake: a method call happens on a posedge where both its __ENA and
// __RDY are high. An ENA without the matching RDY is ignored and leaves state
// unchanged. Each RDY is a function of registered state only. pipe_enq__ENA
// is asserted only when a word is present and pipe_enq__RDY is high, and the
// word counts as delivered on that same edge.

module echo_indication_output #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_HEARD  = 1,
  parameter int unsigned TAG_HEARD2 = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        indication_heard__ENA,
  input  logic [31:0] indication_heard_meth,
  input  logic [31:0] indication_heard_v,
  output logic        indication_heard__RDY,
  input  logic        indication_heard2__ENA,
  input  logic [31:0] indication_heard2_a,
  input  logic [31:0] indication_heard2_b,
  output logic        indication_heard2__RDY,
  output logic        pipe_enq__ENA,
  output logic [95:0] pipe_enq_v,
  input  logic        pipe_enq__RDY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic          push_a;
  logic          push_b;
  logic          pop;
  logic [1:0]    n_push;
  logic [AW-1:0] wptr_b;
  logic [95:0]   word_a;
  logic [95:0]   word_b;

  // heard2 needs one spare slot beyond heard so that both calls can be
  // accepted together without overflowing.
  assign indication_heard__RDY  = (count < DEPTH_C);
  assign indication_heard2__RDY = (count < DEPTH_M1_C);

  assign push_a = indication_heard__ENA  && indication_heard__RDY;
  assign push_b = indication_heard2__ENA && indication_heard2__RDY;
  assign pop    = (count != '0) && pipe_enq__RDY;
  assign n_push = {1'b0, push_a} + {1'b0, push_b};

  assign word_a = {indication_heard_v, indication_heard_meth, 32'(TAG_HEARD)};
  assign word_b = {indication_heard2_b, indication_heard2_a, 32'(TAG_HEARD2)};

  // When both calls are accepted, heard takes the slot at wptr and heard2
  // takes the slot after it, which keeps heard ahead of heard2 in the output.
  assign wptr_b = push_a ? (wptr + AW'(1)) : wptr;

  assign pipe_enq__ENA = pop;
  assign pipe_enq_v    = mem[rptr];

  // Storage is not reset. Words that were buffered before a reset cannot be
  // read again because count returns to zero.
  always_ff @(posedge CLK) begin
    if (push_a) mem[wptr]   <= word_a;
    if (push_b) mem[wptr_b] <= word_b;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(n_push);
      rptr  <= rptr + AW'(pop);
      count <= count + CW'(n_push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_echo_indication_output.sv
// tb_echo_indication_output
//
// Directed stimulus for echo_indication_output. Driver tasks push the words
// they expect into exp_q when a call is accepted. A monitor at each negedge
// checks the RDY and ENA outputs against the queue occupancy, then pops the
// head of exp_q and compares it with the word the DUT emitted.

module tb_echo_indication_output;

  localparam int DEPTH = 4;

  logic        clk;
  logic        n_rst;
  logic        h_ena;
  logic [31:0] h_meth;
  logic [31:0] h_v;
  logic        h_rdy;
  logic        h2_ena;
  logic [31:0] h2_a;
  logic [31:0] h2_b;
  logic        h2_rdy;
  logic        p_ena;
  logic [95:0] p_v;
  logic        p_rdy;

  logic [95:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  bit          chk_en;

  echo_indication_output #(
    .DEPTH      (DEPTH),
    .TAG_HEARD  (1),
    .TAG_HEARD2 (2)
  ) dut (
    .CLK                    (clk),
    .nRST                   (n_rst),
    .indication_heard__ENA  (h_ena),
    .indication_heard_meth  (h_meth),
    .indication_heard_v     (h_v),
    .indication_heard__RDY  (h_rdy),
    .indication_heard2__ENA (h2_ena),
    .indication_heard2_a    (h2_a),
    .indication_heard2_b    (h2_b),
    .indication_heard2__RDY (h2_rdy),
    .pipe_enq__ENA          (p_ena),
    .pipe_enq_v             (p_v),
    .pipe_enq__RDY          (p_rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] pack(input logic [31:0] tag, input logic [31:0] f1,
                                       input logic [31:0] f2);
    return {f2, f1, tag};
  endfunction

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic call(input bit do_h, input logic [31:0] m, input logic [31:0] v,
                      input bit do_h2, input logic [31:0] a, input logic [31:0] b);
    h_ena  = do_h;
    h_meth = m;
    h_v    = v;
    h2_ena = do_h2;
    h2_a   = a;
    h2_b   = b;
    @(posedge clk);
    if (do_h)  exp_q.push_back(pack(32'd1, m, v));
    if (do_h2) exp_q.push_back(pack(32'd2, a, b));
    #1;
    h_ena  = 1'b0;
    h2_ena = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1;
    n_rst = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 96'(exp_q.size()), 96'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("heard_rdy", 96'(h_rdy), 96'(exp_q.size() < DEPTH));
      check("heard2_rdy", 96'(h2_rdy), 96'(exp_q.size() < DEPTH - 1));
      check("enq_ena", 96'(p_ena), 96'((exp_q.size() != 0) && p_rdy));
      if (p_ena === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none at %0t", p_v, $time);
        end else begin
          check("enq_word", p_v, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    n_rst    = 1'b0;
    h_ena    = 1'b0;
    h_meth   = '0;
    h_v      = '0;
    h2_ena   = 1'b0;
    h2_a     = '0;
    h2_b     = '0;
    p_rdy    = 1'b0;

    // Reset held for 3 cycles. The monitor is enabled after the first edge.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(2);
    n_rst = 1'b1;
    check("reset_ena", 96'(p_ena), 96'd0);
    check("reset_heard_rdy", 96'(h_rdy), 96'd1);
    check("reset_heard2_rdy", 96'(h2_rdy), 96'd1);
    idle(2);

    // Single heard pass-through.
    p_rdy = 1'b1;
    call(1'b1, 32'h11, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    check("single_word", p_v, 96'hDEADBEEF_00000011_00000001);
    check("single_ena", 96'(p_ena), 96'd1);
    idle(1);
    check("single_ena_after", 96'(p_ena), 96'd0);

    // Both calls in the same cycle.
    call(1'b1, 32'd5, 32'd6, 1'b1, 32'd7, 32'd8);
    check("both_first", p_v, 96'h00000006_00000005_00000001);
    idle(1);
    check("both_second", p_v, 96'h00000008_00000007_00000002);
    idle(2);

    // Fill with backpressure, then drain.
    p_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      call(1'b1, 32'(i), 32'(i * 16), 1'b0, 32'h0, 32'h0);
      if (i == 3) check("fill_heard2_rdy_low", 96'(h2_rdy), 96'd0);
      if (i == 4) check("fill_heard_rdy_low", 96'(h_rdy), 96'd0);
    end
    idle(2);
    p_rdy = 1'b1;
    wait_drain("fill_drain");
    idle(1);

    // Wrap-around: alternating calls while downstream toggles ready.
    for (int i = 0; i < 20; i++) begin
      p_rdy = (i % 2 == 0);
      if (i % 2 == 0 && h_rdy)
        call(1'b1, 32'(i), 32'(32'h100 + i), 1'b0, 32'h0, 32'h0);
      else if (i % 2 == 1 && h2_rdy)
        call(1'b0, 32'h0, 32'h0, 1'b1, 32'(32'h200 + i), 32'(32'h300 + i));
      else
        idle(1);
    end
    p_rdy = 1'b1;
    wait_drain("wrap_drain");
    idle(1);

    // Reset mid-stream discards buffered words.
    p_rdy = 1'b0;
    call(1'b1, 32'hA1, 32'hB1, 1'b0, 32'h0, 32'h0);
    call(1'b0, 32'h0, 32'h0, 1'b1, 32'hA2, 32'hB2);
    call(1'b1, 32'hA3, 32'hB3, 1'b0, 32'h0, 32'h0);
    pulse_reset();
    p_rdy = 1'b1;
    idle(3);
    check("post_reset_idle_ena", 96'(p_ena), 96'd0);
    call(1'b1, 32'hC0FFEE, 32'h12345678, 1'b0, 32'h0, 32'h0);
    check("post_reset_first", p_v, 96'h12345678_00C0FFEE_00000001);
    wait_drain("post_reset_drain");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
